// File: rtl/benes_cfg_sequencer_pkg.sv
// Shared parameters and types for the Benes switch-configuration path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package benes_cfg_sequencer_pkg;

   localparam int SIZE       = 32;
   localparam int SWITCH_NUM = SIZE / 2;
   localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
   localparam int CFG_DEPTH  = 16;
   localparam int AW         = $clog2(CFG_DEPTH);
   localparam int SW         = $clog2(STAGE_NUM);

   // One stage word: bit i set = switch i crossed, clear = bar.
   typedef logic [SWITCH_NUM-1:0] benes_word_t;

   // Full network setting, stage 0 first; same type as the interconnect's switch_set ports.
   typedef benes_word_t [0:STAGE_NUM-1] benes_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } seq_state_t;

   // Pattern pointer step; CFG_DEPTH is a power of two so the AW-bit add wraps to entry 0.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/benes_cfg_sequencer_ram.sv
// Pattern storage: CFG_DEPTH entries x STAGE_NUM stage words, per-stage write, full-entry read.
// Latency: read data registered, visible the cycle after rd_en; read-first on same-entry collisions.
// Backpressure: none; read register holds its value whenever rd_en is low.
module benes_cfg_sequencer_ram
   import benes_cfg_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_idx,
   input  logic [SW-1:0]    wr_stage,
   input  benes_word_t      wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_idx,
   output benes_cfg_t       rd_data
);

   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_NUM - 1);

   benes_cfg_t mem [CFG_DEPTH];
   benes_cfg_t rd_data_d;
   benes_cfg_t rd_data_q;

   // Storage array: no reset, stage indices past the last stage are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_stage <= STAGE_LAST)) begin
         mem[wr_idx][wr_stage] <= wr_data;
      end
   end

   // Read register only loads on a read, so the network sees a stable setting otherwise.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_idx];
      end
   end

   // Read register resets to all-bar; nonblocking update gives read-first on collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/benes_cfg_sequencer.sv
// Replays a contiguous, wrapping run of stored Benes settings onto switch_set, one per advance.
// Latency: accept->RUN 1 cycle; read issued in RUN with i_advance appears on outputs next cycle.
// Backpressure: i_advance stalls the run (outputs hold); o_cmd_ready only high in IDLE.
module benes_cfg_sequencer
   import benes_cfg_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cfg_wr_en,
   input  logic [AW-1:0]    i_cfg_wr_idx,
   input  logic [SW-1:0]    i_cfg_wr_stage,
   input  benes_word_t      i_cfg_wr_data,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [AW-1:0]    i_cmd_base,
   input  logic [AW:0]      i_cmd_len,
   input  logic             i_advance,
   input  logic             i_abort,
   output benes_cfg_t       o_switch_set,
   output logic             o_cfg_valid,
   output logic [AW-1:0]    o_cfg_idx,
   output logic             o_done,
   output logic             o_busy
);

   seq_state_t       state_d,     state_q;
   logic [AW-1:0]    rd_ptr_d,    rd_ptr_q;
   logic [AW:0]      remain_d,    remain_q;
   logic             cfg_valid_d, cfg_valid_q;
   logic [AW-1:0]    cfg_idx_d,   cfg_idx_q;
   logic             done_d,      done_q;
   logic             busy_d,      busy_q;
   logic             cmd_ready_d, cmd_ready_q;

   logic             rd_en;
   logic             accept;

   assign rd_en  = (state_q == ST_RUN) && i_advance;
   assign accept = i_cmd_valid && cmd_ready_q;

   // The RAM read register doubles as the pattern register, giving the one-cycle read-to-output path.
   benes_cfg_sequencer_ram u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (i_cfg_wr_en),
      .wr_idx   (i_cfg_wr_idx),
      .wr_stage (i_cfg_wr_stage),
      .wr_data  (i_cfg_wr_data),
      .rd_en    (rd_en),
      .rd_idx   (rd_ptr_q),
      .rd_data  (o_switch_set)
   );

   // Next-state: command latch, read pointer walk, run termination and abort.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remain_d    = remain_q;
      cfg_valid_d = rd_en;
      cfg_idx_d   = rd_en ? rd_ptr_q : cfg_idx_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_ptr_d = i_cmd_base;
               remain_d = i_cmd_len;
               if (i_cmd_len == '0) begin
                  // Empty run: go straight to the completion cycle without touching storage.
                  state_d = ST_FLUSH;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (rd_en) begin
               rd_ptr_d = ptr_inc(rd_ptr_q);
               remain_d = remain_q - 1'b1;
               if (remain_q == (AW+1)'(1)) begin
                  state_d = ST_FLUSH;
                  done_d  = 1'b1;
               end
            end
            // Abort wins over completion; a read issued this cycle is still delivered.
            if (i_abort) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end
         ST_FLUSH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d      = (state_d != ST_IDLE);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // Sequencer state and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_ptr_q    <= '0;
         remain_q    <= '0;
         cfg_valid_q <= 1'b0;
         cfg_idx_q   <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         remain_q    <= remain_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_idx_q   <= cfg_idx_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign o_cfg_valid = cfg_valid_q;
   assign o_cfg_idx   = cfg_idx_q;
   assign o_done      = done_q;
   assign o_busy      = busy_q;
   assign o_cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Directed and randomized runs against a pattern-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_benes_cfg_sequencer;
   import benes_cfg_sequencer_pkg::*;

   localparam int CW = SWITCH_NUM * STAGE_NUM;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_cfg_wr_en;
   logic [AW-1:0]    i_cfg_wr_idx;
   logic [SW-1:0]    i_cfg_wr_stage;
   benes_word_t      i_cfg_wr_data;
   logic             i_cmd_valid;
   logic             o_cmd_ready;
   logic [AW-1:0]    i_cmd_base;
   logic [AW:0]      i_cmd_len;
   logic             i_advance;
   logic             i_abort;
   benes_cfg_t       o_switch_set;
   logic             o_cfg_valid;
   logic [AW-1:0]    o_cfg_idx;
   logic             o_done;
   logic             o_busy;

   int checks = 0;
   int errors = 0;

   benes_cfg_t exp_mem [CFG_DEPTH];
   benes_cfg_t last_dat;

   benes_cfg_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_cfg_wr_en    (i_cfg_wr_en),
      .i_cfg_wr_idx   (i_cfg_wr_idx),
      .i_cfg_wr_stage (i_cfg_wr_stage),
      .i_cfg_wr_data  (i_cfg_wr_data),
      .i_cmd_valid    (i_cmd_valid),
      .o_cmd_ready    (o_cmd_ready),
      .i_cmd_base     (i_cmd_base),
      .i_cmd_len      (i_cmd_len),
      .i_advance      (i_advance),
      .i_abort        (i_abort),
      .o_switch_set   (o_switch_set),
      .o_cfg_valid    (o_cfg_valid),
      .o_cfg_idx      (o_cfg_idx),
      .o_done         (o_done),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int k, input int s, input logic [15:0] d);
      i_cfg_wr_en    = 1'b1;
      i_cfg_wr_idx   = AW'(k);
      i_cfg_wr_stage = SW'(s);
      i_cfg_wr_data  = d;
      tick();
      i_cfg_wr_en    = 1'b0;
      if (s < STAGE_NUM) exp_mem[k][s] = d;
   endtask

   // mode 0: advance always; 1: random advance; 2: advance pattern 1,0,0,1,1 then 1.
   // abort_at: raise abort together with the read of that number (1-based), 0 = never.
   // coll: write entry/stage 3 in the same cycle as the first read of the run.
   task automatic do_run(input int base, input int len, input int mode, input int abort_at, input bit coll);
      int         reads;
      int         ptr;
      int         nidx;
      bit         active, adv, ab, nv, nd;
      benes_cfg_t ndat;
      logic [15:0] d;
      bit         pat [5];
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      reads  = 0;
      ptr    = base;
      ab     = 1'b0;
      nidx   = 0;
      ndat   = '0;
      chk("ready_before_cmd", o_cmd_ready, 1);
      i_cmd_valid = 1'b1;
      i_cmd_base  = AW'(base);
      i_cmd_len   = (AW+1)'(len);
      tick();
      i_cmd_valid = 1'b0;
      chk("busy_after_accept", o_busy, 1);
      chk("ready_after_accept", o_cmd_ready, 0);
      chk("valid_after_accept", o_cfg_valid, 0);
      chk("done_after_accept", o_done, len == 0);
      active = (len != 0);
      for (int c = 0; c < 200 && active; c++) begin
         case (mode)
            0:       adv = 1'b1;
            1:       adv = ($urandom_range(0, 3) != 0);
            default: adv = (c < 5) ? pat[c] : 1'b1;
         endcase
         nv = 1'b0;
         nd = 1'b0;
         if (adv) begin
            nv   = 1'b1;
            nidx = ptr;
            ndat = exp_mem[ptr];
            reads++;
            ptr  = (ptr + 1) % CFG_DEPTH;
            if (reads == len) begin
               active = 1'b0;
               nd     = 1'b1;
            end
            if (abort_at != 0 && reads == abort_at) begin
               ab     = 1'b1;
               active = 1'b0;
               nd     = 1'b0;
            end
            if (coll && reads == 1) begin
               d              = 16'($urandom);
               i_cfg_wr_en    = 1'b1;
               i_cfg_wr_idx   = AW'(nidx);
               i_cfg_wr_stage = SW'(3);
               i_cfg_wr_data  = d;
               exp_mem[nidx][3] = d;
            end
         end
         i_advance = adv;
         i_abort   = ab;
         tick();
         i_advance   = 1'b0;
         i_abort     = 1'b0;
         i_cfg_wr_en = 1'b0;
         chk("cfg_valid", o_cfg_valid, nv);
         chk("done", o_done, nd);
         if (nv) begin
            chk("cfg_idx", o_cfg_idx, nidx);
            chk("switch_set", o_switch_set, ndat);
            last_dat = ndat;
         end else begin
            chk("switch_hold", o_switch_set, last_dat);
         end
      end
      if (active) chk("run_timeout", reads, len);
      if (ab) begin
         chk("ready_after_abort", o_cmd_ready, 1);
         chk("busy_after_abort", o_busy, 0);
      end
      // Idle cycle with advance high: must be ignored.
      i_advance = 1'b1;
      tick();
      i_advance = 1'b0;
      chk("idle_valid", o_cfg_valid, 0);
      chk("idle_done", o_done, 0);
      chk("idle_ready", o_cmd_ready, 1);
      chk("idle_busy", o_busy, 0);
      chk("idle_hold", o_switch_set, last_dat);
   endtask

   initial begin
      int b, l, a;
      rst_n          = 1'b0;
      i_cfg_wr_en    = 1'b0;
      i_cfg_wr_idx   = '0;
      i_cfg_wr_stage = '0;
      i_cfg_wr_data  = '0;
      i_cmd_valid    = 1'b0;
      i_cmd_base     = '0;
      i_cmd_len      = '0;
      i_advance      = 1'b0;
      i_abort        = 1'b0;
      last_dat       = '0;
      #12;
      chk("rst_switch_set", o_switch_set, 0);
      chk("rst_cfg_valid", o_cfg_valid, 0);
      chk("rst_cfg_idx", o_cfg_idx, 0);
      chk("rst_done", o_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cmd_ready", o_cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fill storage: formula entries 0..7, random entries 8..15.
      for (int k = 0; k < CFG_DEPTH; k++) begin
         for (int s = 0; s < STAGE_NUM; s++) begin
            if (k < 8) wr(k, s, 16'hA5A5 ^ 16'((k << 4) | s));
            else       wr(k, s, 16'($urandom));
         end
      end
      // Out-of-range stage index: must not disturb anything.
      wr(0, 12, 16'hFFFF);
      wr(1, 15, 16'h0F0F);

      do_run(0, 4, 0, 0, 1'b0);    // basic replay
      do_run(14, 4, 0, 0, 1'b0);   // pointer wrap 14,15,0,1
      do_run(2, 3, 2, 0, 1'b0);    // stall pattern
      do_run(7, 0, 0, 0, 1'b0);    // empty run
      do_run(0, 8, 0, 2, 1'b0);    // abort on second read

      // Reset mid-run, then confirm storage survived.
      i_cmd_valid = 1'b1;
      i_cmd_base  = '0;
      i_cmd_len   = (AW+1)'(8);
      tick();
      i_cmd_valid = 1'b0;
      i_advance   = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_switch_set", o_switch_set, 0);
      chk("midrst_cfg_valid", o_cfg_valid, 0);
      chk("midrst_cfg_idx", o_cfg_idx, 0);
      chk("midrst_done", o_done, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_cmd_ready", o_cmd_ready, 1);
      i_advance = 1'b0;
      last_dat  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_run(0, 4, 0, 0, 1'b0);

      // Read-first collision on entry 5, then the new data on a rerun.
      do_run(5, 1, 0, 0, 1'b1);
      do_run(5, 1, 0, 0, 1'b0);

      // Randomized runs with random stalls, occasional aborts and fresh writes between.
      for (int r = 0; r < 10; r++) begin
         wr($urandom_range(0, CFG_DEPTH - 1), $urandom_range(0, STAGE_NUM - 1), 16'($urandom));
         b = $urandom_range(0, CFG_DEPTH - 1);
         l = $urandom_range(1, CFG_DEPTH);
         a = 0;
         if ((r % 3) == 0 && l > 2) a = $urandom_range(1, l - 1);
         do_run(b, l, 1, a, 1'b0);
      end

      // Full-depth run from a random base.
      b = $urandom_range(0, CFG_DEPTH - 1);
      do_run(b, CFG_DEPTH, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
